fw_unit: RTL

FW_UNIT -- requirements
Module: fw_unit

---
 rtl/fw_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/fw_unit.sv
// Operand forwarding and scoreboard interlock: resolves up to three operands from pipeline taps
// or the register file. Define FW_STALL_STATS_EN to add the saturating stall_count output.
module fw_unit #(
   parameter int NSTAGES = 7
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic                   src_valid,
   input  logic [2:0]             src_en,
   input  logic [20:0]            src_addr,
   input  logic [383:0]           rf_value,
   input  logic                   issue_wr,
   input  logic [6:0]             issue_target,
   input  logic [3:0]             issue_latency,
   input  logic [NSTAGES-1:0]     tap_wr,
   input  logic [7*NSTAGES-1:0]   tap_target,
   input  logic [128*NSTAGES-1:0] tap_value,
   input  logic [4*NSTAGES-1:0]   tap_stage,
   output logic                   stall,
   output logic                   op_valid,
   output logic [383:0]           op_value,
   output logic [2:0]             op_fwd
`ifdef FW_STALL_STATS_EN
   ,
   output logic [31:0]            stall_count
`endif
);

   logic [3:0]   sb_q [128];
   logic [2:0]   tap_hit;
   logic [2:0]   tap_rdy;
   logic [127:0] tap_sel [3];
   logic [2:0]   opnd_stall;
   logic [2:0]   opnd_fwd;
   logic [383:0] opnd_value;
   logic         accept;

   // Walk taps oldest to youngest so the lowest matching index wins.
   always_comb begin
      tap_hit    = '0;
      tap_rdy    = '0;
      opnd_stall = '0;
      opnd_fwd   = '0;
      opnd_value = '0;
      for (int k = 0; k < 3; k++) begin
         tap_sel[k] = '0;
         for (int i = NSTAGES - 1; i >= 0; i--) begin
            if (tap_wr[i] && (tap_target[7*i +: 7] == src_addr[7*k +: 7])) begin
               tap_hit[k] = 1'b1;
               tap_rdy[k] = ({28'd0, tap_stage[4*i +: 4]} <= $unsigned(i + 1));
               tap_sel[k] = tap_value[128*i +: 128];
            end
         end
         if (src_en[k]) begin
            opnd_stall[k] = (sb_q[src_addr[7*k +: 7]] != 4'd0) || (tap_hit[k] && !tap_rdy[k]);
            opnd_fwd[k]   = tap_hit[k] && tap_rdy[k];
            opnd_value[128*k +: 128] = opnd_fwd[k] ? tap_sel[k] : rf_value[128*k +: 128];
         end
      end
   end

   assign stall  = src_valid && (|opnd_stall);
   assign accept = src_valid && !stall && !flush;

   // A fresh issue load takes precedence over the countdown of the same entry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < 128; e++) sb_q[e] <= 4'd0;
      end else if (flush) begin
         for (int e = 0; e < 128; e++) sb_q[e] <= 4'd0;
      end else begin
         for (int e = 0; e < 128; e++) begin
            if (accept && issue_wr && (issue_target == 7'(e))) begin
               sb_q[e] <= issue_latency;
            end else if (sb_q[e] != 4'd0) begin
               sb_q[e] <= sb_q[e] - 4'd1;
            end
         end
      end
   end

   // op_value deliberately holds across flush and idle cycles.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_valid <= 1'b0;
         op_value <= '0;
         op_fwd   <= '0;
      end else if (flush) begin
         op_valid <= 1'b0;
         op_fwd   <= '0;
      end else begin
         op_valid <= accept;
         if (accept) begin
            op_value <= opnd_value;
            op_fwd   <= opnd_fwd;
         end
      end
   end

`ifdef FW_STALL_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
      end else if (flush) begin
         stall_count <= '0;
      end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
